// File: rtl/fetch_stage_ctrl_if.sv
// Instruction-memory req/ack fetch bundle.
// master: fetch unit (req/addr out), slave: imem (ack/rdata out).
interface fetch_stage_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns PC, IF/ID register and imem req/ack fetch.
// Ports: clk, rst (sync, active-high); hazard controls holdPC,
//   IF_ID_Flush, isBranch/PC_offset/branch_pc4, isJump/jump_addr;
//   imem (fetch_stage_ctrl_if.master); IF/ID outputs if_id_instr,
//   if_id_pc4, if_id_valid; current fetch pc.
// Optional macro IF_PERF_CNT_EN adds perf_fetch/perf_stall/perf_flush.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                holdPC,
    input  logic                IF_ID_Flush,
    input  logic                isBranch,
    input  logic [31:0]         PC_offset,
    input  logic [31:0]         branch_pc4,
    input  logic                isJump,
    input  logic [31:0]         jump_addr,
    fetch_stage_ctrl_if.master  imem,
    output logic [31:0]         if_id_instr,
    output logic [31:0]         if_id_pc4,
    output logic                if_id_valid,
    output logic [31:0]         pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    perf_fetch,
    output logic [CNT_W-1:0]    perf_stall,
    output logic [CNT_W-1:0]    perf_flush
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    logic        w_ack;
    logic        w_redir;
    logic [31:0] w_target;
    logic [31:0] w_pc4;
    logic        w_take;
    logic        w_load;
    logic        w_bubble;
    logic [31:0] w_next_pc;

    assign w_ack    = r_req & imem.imem_ack;
    assign w_redir  = isBranch | isJump;
    assign w_target = isBranch ? (branch_pc4 + (PC_offset << 2))
                               : jump_addr;
    assign w_pc4    = r_pc + 32'd4;

    // Only a FETCH-state ack belongs to the current pc; a DRAIN ack
    // returns data for an abandoned address and is dropped.
    assign w_take   = (r_state == S_FETCH) & w_ack & ~w_redir & ~holdPC;
    assign w_load   = w_take & ~IF_ID_Flush;
    assign w_bubble = w_redir | IF_ID_Flush;

    assign w_next_pc = w_redir ? w_target :
                       w_take  ? w_pc4    : r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_bubble) begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
            end else if (w_load) begin
                r_instr <= imem.imem_rdata;
                r_pc4   <= w_pc4;
                r_valid <= 1'b1;
            end
            // The address may only move when no request is pending,
            // i.e. out of IDLE or on an ack.
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= w_next_pc;
                end
                S_FETCH: begin
                    if (w_ack) begin
                        r_addr <= w_next_pc;
                    end else if (w_redir) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_ack) begin
                        r_addr  <= w_next_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;
    assign if_id_instr    = r_instr;
    assign if_id_pc4      = r_pc4;
    assign if_id_valid    = r_valid;
    assign pc             = r_pc;

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] r_pf_fetch;
    logic [CNT_W-1:0] r_pf_stall;
    logic [CNT_W-1:0] r_pf_flush;
    logic             w_stall;

    assign w_stall = holdPC | (r_req & ~imem.imem_ack);

    // Saturating counters: stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pf_fetch <= '0;
            r_pf_stall <= '0;
            r_pf_flush <= '0;
        end else begin
            if (w_load && (r_pf_fetch != '1))
                r_pf_fetch <= r_pf_fetch + CNT_W'(1);
            if (w_stall && (r_pf_stall != '1))
                r_pf_stall <= r_pf_stall + CNT_W'(1);
            if (w_bubble && (r_pf_flush != '1))
                r_pf_flush <= r_pf_flush + CNT_W'(1);
        end
    end

    assign perf_fetch = r_pf_fetch;
    assign perf_stall = r_pf_stall;
    assign perf_flush = r_pf_flush;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
